// File: rtl/adder_8bit_reg_pkg.sv
// Shared types for the registered adder: operand width, result bundle and flag helper.
package adder_pkg;

  localparam int ADDER_WIDTH = 8;

  typedef logic [ADDER_WIDTH-1:0] operand_t;

  typedef struct packed {
    operand_t sum;
    logic     carry_out;
    logic     overflow;
    logic     zero;
  } adder_result_t;

  // Two's-complement overflow: like-signed operands producing a sum of the other sign.
  function automatic logic signed_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/adder_8bit_reg_if.sv
// Operand/result bundle between an upstream operand driver and the registered adder.
interface adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             carry_in;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, operand_a, operand_b, carry_in,
    input  out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, operand_a, operand_b, carry_in,
    output out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/adder_8bit_reg_full_cell.sv
// One-bit full adder; the ripple chain in adder_8bit_reg is built from these.
module adder_full_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p_s;

  assign p_s  = a ^ b;
  assign s    = p_s ^ cin;
  assign cout = (a & b) | (cin & p_s);
endmodule

// File: rtl/adder_8bit_reg.sv
// Registered ripple-carry adder: results and flags appear one clock after an accepted input
// and hold while no new input is offered.
module adder_8bit_reg
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input logic    clk,
  input logic    rst,
  adder_if.slave bus
);

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;
  adder_result_t    next_s;
  adder_result_t    result_r;
  logic             valid_r;

  assign carry_s[0] = bus.carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    adder_full_cell u_cell (
      .a    (bus.operand_a[i]),
      .b    (bus.operand_b[i]),
      .cin  (carry_s[i]),
      .s    (sum_s[i]),
      .cout (carry_s[i+1])
    );
  end

  // Assemble the next result and its flags from the ripple chain.
  always_comb begin
    next_s           = '0;
    next_s.sum       = sum_s;
    next_s.carry_out = carry_s[WIDTH];
    next_s.overflow  = signed_overflow(bus.operand_a[WIDTH-1], bus.operand_b[WIDTH-1],
                                       sum_s[WIDTH-1]);
    next_s.zero      = (sum_s == '0);
  end

  // Capture on accepted input; otherwise hold the result and drop out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= '0;
      valid_r  <= 1'b0;
    end else if (bus.in_valid) begin
      result_r <= next_s;
      valid_r  <= 1'b1;
    end else begin
      result_r <= result_r;
      valid_r  <= 1'b0;
    end
  end

  assign bus.out_valid = valid_r;
  assign bus.sum       = result_r.sum;
  assign bus.carry_out = result_r.carry_out;
  assign bus.overflow  = result_r.overflow;
  assign bus.zero      = result_r.zero;

endmodule

// File: tb/tb_adder_8bit_reg.sv
// Randomised and directed checking of adder_8bit_reg against an arithmetic reference model.
module tb_adder_8bit_reg;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  int   exp_valid;
  int   exp_sum;
  int   exp_co;
  int   exp_ov;
  int   exp_zero;

  adder_if #(.WIDTH(8)) bus ();

  adder_8bit_reg #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, want, want, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"}, int'(bus.out_valid), exp_valid);
    check({tag, ".sum"}, int'(bus.sum), exp_sum);
    check({tag, ".carry_out"}, int'(bus.carry_out), exp_co);
    check({tag, ".overflow"}, int'(bus.overflow), exp_ov);
    check({tag, ".zero"}, int'(bus.zero), exp_zero);
  endtask

  // Reference: integer arithmetic, signed overflow from the true signed sum range.
  task automatic model(input int r, input int v, input int a, input int b, input int c);
    int full;
    int sa;
    int sb;
    int ssum;
    if (r != 0) begin
      exp_valid = 0; exp_sum = 0; exp_co = 0; exp_ov = 0; exp_zero = 0;
    end else if (v != 0) begin
      full      = a + b + c;
      sa        = (a >= 128) ? a - 256 : a;
      sb        = (b >= 128) ? b - 256 : b;
      ssum      = sa + sb + c;
      exp_valid = 1;
      exp_sum   = full % 256;
      exp_co    = (full > 255) ? 1 : 0;
      exp_ov    = (ssum > 127 || ssum < -128) ? 1 : 0;
      exp_zero  = (exp_sum == 0) ? 1 : 0;
    end else begin
      exp_valid = 0;
    end
  endtask

  task automatic step(input string tag, input int r, input int v, input int a, input int b, input int c);
    @(negedge clk);
    rst           = r[0];
    bus.in_valid  = v[0];
    bus.operand_a = a[7:0];
    bus.operand_b = b[7:0];
    bus.carry_in  = c[0];
    @(posedge clk);
    model(r, v, a, b, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_valid = 0; exp_sum = 0; exp_co = 0; exp_ov = 0; exp_zero = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.operand_a = 8'h00;
    bus.operand_b = 8'h00;
    bus.carry_in  = 1'b0;

    step("reset0", 1, 0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 0);
    step("released", 0, 0, 0, 0, 0);

    step("add10_20", 0, 1, 10, 20, 0);
    step("add15_25", 0, 1, 15, 25, 0);
    step("wrap_ff_01", 0, 1, 255, 1, 0);
    step("cin_ff_00", 0, 1, 255, 0, 1);
    step("ovf_7f_01", 0, 1, 127, 1, 0);
    step("ovf_80_80", 0, 1, 128, 128, 0);
    step("add10_20b", 0, 1, 10, 20, 0);
    step("hold", 0, 0, 99, 77, 1);
    step("hold2", 0, 0, 200, 200, 0);
    step("rst_prio", 1, 1, 50, 60, 0);
    step("after_rst", 0, 0, 1, 2, 0);
    step("neg_small", 0, 1, 200, 100, 1);
    step("rst_mid", 1, 0, 0, 0, 0);
    step("after_rst2", 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 49) == 0) ? 1 : 0,
           ($urandom_range(0, 3) != 0) ? 1 : 0,
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
